// File: rtl/regfile_pkg.sv
// Shared sizing constants and the write-enable decode for the 32x32 register file.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_WIDTH = 32;
  localparam int IDX_WIDTH = 5;
  localparam int ZERO_REG  = 0;

  typedef logic [REG_WIDTH-1:0] word_t;
  typedef logic [IDX_WIDTH-1:0] idx_t;

  // One-hot 5-to-32 write enable; register 0 is hardwired and never enabled.
  function automatic logic [REG_COUNT-1:0] decode_wr(input logic en, input idx_t idx);
    logic [REG_COUNT-1:0] oh;
    oh           = '0;
    oh[idx]      = en;
    oh[ZERO_REG] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_reg32.sv
// Single 32-bit storage register with load enable and asynchronous active-high clear.
module reg32
  import regfile_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [REG_WIDTH-1:0] d,
  output logic [REG_WIDTH-1:0] q
);

  logic [REG_WIDTH-1:0] data_d;
  logic [REG_WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/regfile.sv
// 32x32 register file: one write port, two combinational read ports with
// write-through bypass so a value being written is visible before the edge.
module regfile
  import regfile_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  logic [REG_COUNT-1:0] wr_en;
  logic [REG_WIDTH-1:0] reg_rd [REG_COUNT];
  logic [REG_WIDTH-1:0] rd_a_raw;
  logic [REG_WIDTH-1:0] rd_b_raw;
  logic                 wr_valid;
  logic                 hit_a;
  logic                 hit_b;

  assign wr_en = decode_wr(ctrl_writeEnable, ctrl_writeReg);

  assign reg_rd[ZERO_REG] = '0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    reg32 u_reg (
      .clock (clock),
      .reset (reset),
      .en    (wr_en[i]),
      .d     (data_writeReg),
      .q     (reg_rd[i])
    );
  end

  always_comb begin
    rd_a_raw = reg_rd[ctrl_readRegA];
    rd_b_raw = reg_rd[ctrl_readRegB];
  end

  assign wr_valid = ctrl_writeEnable && (ctrl_writeReg != IDX_WIDTH'(ZERO_REG));
  assign hit_a    = wr_valid && (ctrl_readRegA == ctrl_writeReg);
  assign hit_b    = wr_valid && (ctrl_readRegB == ctrl_writeReg);

  // Reset forces both outputs to zero so a pending write cannot bypass through.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    if (!reset) begin
      data_readRegA = hit_a ? data_writeReg : rd_a_raw;
      data_readRegB = hit_b ? data_writeReg : rd_b_raw;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a reference model feeds an expectation
// queue that each scenario pops and compares against the read ports.
module tb_regfile;

  logic        clock;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          tests_run;
  int          tests_failed;

  regfile dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one write cycle and update the model; disabled or r0 writes leave it unchanged.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data, input logic we);
    @(negedge clock);
    ctrl_writeEnable = we;
    ctrl_writeReg    = idx;
    data_writeReg    = data;
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    if (we && idx != 5'd0 && !reset) model[idx] = data;
  endtask

  task automatic push_read(input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    e.a = reset ? 32'h0 : model[a];
    e.b = reset ? 32'h0 : model[b];
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    #2;
    for (int i = 0; i < 32; i++) begin
      push_read(5'(i), 5'(31 - i));
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (data_readRegA !== e.a || data_readRegB !== e.b) begin
        tests_failed++;
        $display("FAIL reset_read idx=%0d got A=%h B=%h want A=%h B=%h", i,
                 data_readRegA, data_readRegB, e.a, e.b);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic_write();
    exp_t e;
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    push_read(5'd5, 5'd5);
    push_read(5'd4, 5'd6);
    for (int k = 0; k < 2; k++) begin
      ctrl_readRegA = (k == 0) ? 5'd5 : 5'd4;
      ctrl_readRegB = (k == 0) ? 5'd5 : 5'd6;
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (data_readRegA !== e.a || data_readRegB !== e.b) begin
        tests_failed++;
        $display("FAIL basic_write step=%0d got A=%h B=%h want A=%h B=%h", k,
                 data_readRegA, data_readRegB, e.a, e.b);
      end
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    do_write(5'd0, 32'h12345678, 1'b1);
    do_write(5'd9, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 32; i++) begin
      push_read(5'(i), 5'(i));
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (data_readRegA !== e.a || data_readRegB !== e.b) begin
        tests_failed++;
        $display("FAIL zero_or_disabled idx=%0d got A=%h B=%h want A=%h B=%h", i,
                 data_readRegA, data_readRegB, e.a, e.b);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    do_write(5'd7, 32'h11111111, 1'b1);
    do_write(5'd3, 32'h33333333, 1'b1);
    @(negedge clock);
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h22222222;
    // Each row: writeEnable, A index, B index, expected A, expected B.
    for (int k = 0; k < 4; k++) begin
      ctrl_writeEnable = (k != 1);
      ctrl_readRegA    = (k == 2) ? 5'd3 : 5'd7;
      ctrl_readRegB    = (k == 0) ? 5'd3 : 5'd7;
      e.a = (k == 1) ? 32'h11111111 : (k == 2) ? 32'h33333333 : 32'h22222222;
      e.b = (k == 0) ? 32'h33333333 : (k == 1) ? 32'h11111111 : 32'h22222222;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (data_readRegA !== e.a || data_readRegB !== e.b) begin
        tests_failed++;
        $display("FAIL bypass row=%0d got A=%h B=%h want A=%h B=%h", k,
                 data_readRegA, data_readRegB, e.a, e.b);
      end
    end
    ctrl_writeEnable = 1'b0;
    @(posedge clock);
    #1;
    push_read(5'd7, 5'd7);
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (data_readRegA !== e.a || data_readRegB !== e.b) begin
      tests_failed++;
      $display("FAIL bypass_no_commit got A=%h B=%h want A=%h B=%h",
               data_readRegA, data_readRegB, e.a, e.b);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_write(5'd3, 32'hFFFFFFFF, 1'b1);
    push_read(5'd3, 5'd5);
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (data_readRegA !== e.a || data_readRegB !== e.b) begin
      tests_failed++;
      $display("FAIL pre_reset got A=%h B=%h want A=%h B=%h",
               data_readRegA, data_readRegB, e.a, e.b);
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    model_clear();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'hAAAAAAAA;
    push_read(5'd3, 5'd3);
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (data_readRegA !== e.a || data_readRegB !== e.b) begin
      tests_failed++;
      $display("FAIL async_reset_immediate got A=%h B=%h want A=%h B=%h",
               data_readRegA, data_readRegB, e.a, e.b);
    end
    @(posedge clock);
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    reset = 1'b0;
    push_read(5'd3, 5'd5);
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (data_readRegA !== e.a || data_readRegB !== e.b) begin
      tests_failed++;
      $display("FAIL write_during_reset got A=%h B=%h want A=%h B=%h",
               data_readRegA, data_readRegB, e.a, e.b);
    end
    do_write(5'd3, 32'h5A5AA5A5, 1'b1);
    push_read(5'd3, 5'd0);
    #1;
    e = sb_q.pop_front();
    tests_run++;
    if (data_readRegA !== e.a || data_readRegB !== e.b) begin
      tests_failed++;
      $display("FAIL first_write_after_reset got A=%h B=%h want A=%h B=%h",
               data_readRegA, data_readRegB, e.a, e.b);
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101, 1'b1);
    do_write(5'd17, 32'h80000001, 1'b1);
    for (int i = 0; i < 32; i++) begin
      push_read(5'(i), 5'(31 - i));
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (data_readRegA !== e.a || data_readRegB !== e.b) begin
        tests_failed++;
        $display("FAIL sweep A=%0d B=%0d got A=%h B=%h want A=%h B=%h", i, 31 - i,
                 data_readRegA, data_readRegB, e.a, e.b);
      end
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    model_clear();

    test_reset();
    test_basic_write();
    test_zero_reg();
    test_bypass();
    test_async_reset();
    test_sweep();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clock and reset.
REQ-002 Port: clock  input  1  master clock; all register writes occur on its rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset; clears all registers.
REQ-004 Port: ctrl_writeEnable  input  1  write strobe for the single write port.
REQ-005 Port: ctrl_writeReg  input  5  destination register index.
REQ-006 Port: data_writeReg  input  32  write data.
REQ-007 Port: ctrl_readRegA  input  5  read port A register index.
REQ-008 Port: ctrl_readRegB  input  5  read port B register index.
REQ-009 Port: data_readRegA  output  32  read port A data.
REQ-010 Port: data_readRegB  output  32  read port B data.

Function
REQ-011 The register file SHALL hold 32 registers of 32 bits, indices 0..31, with one write port and two independent read ports.
REQ-012 Register 0 SHALL always read 0x00000000, and writes to index 0 SHALL be discarded with no storage change.
REQ-013 A write SHALL occur on the rising edge of clock when ctrl_writeEnable=1 and ctrl_writeReg!=0, storing data_writeReg into the addressed register only.
REQ-014 No register SHALL change when ctrl_writeEnable=0, regardless of the other write inputs.
REQ-015 Reads SHALL be combinational, giving zero-cycle latency from index change to data output.
REQ-016 Write-through bypass: when ctrl_writeEnable=1, ctrl_writeReg!=0 and ctrl_readRegX==ctrl_writeReg, data_readRegX SHALL equal data_writeReg in the same cycle, before the edge; this resolves the writeback-to-decode hazard without a processor bypass.
REQ-017 The bypass SHALL apply to each read port independently, and both ports SHALL be bypassed when both match.
REQ-018 Both ports SHALL be able to read the same index simultaneously and return identical data.
REQ-019 Write data SHALL be taken at full 32-bit width with no sign or zero extension and no truncation.
REQ-020 If reset is asserted in the same cycle as a write, reset SHALL win and the register SHALL hold 0 after reset deasserts.

Reset
REQ-021 While reset=1, all 32 registers SHALL be 0x00000000 asynchronously, without waiting for a clock edge.
REQ-022 While reset=1, data_readRegA and data_readRegB SHALL output 0x00000000, with the bypass suppressed.
REQ-023 After reset deasserts, the first rising edge with a qualifying write SHALL update the register normally.

Structure
REQ-024 A shared package SHALL define REG_COUNT=32, REG_WIDTH=32, IDX_WIDTH=5 and ZERO_REG=0.
REQ-025 One sub-module, reg32 (32-bit register, rising edge, enable, async active-high clear), SHALL be instantiated 31 times for indices 1..31.
REQ-026 Write decode SHALL be a one-hot 5-to-32 enable qualified by ctrl_writeEnable, with bit 0 forced to 0.
REQ-027 Read select SHALL be a 32:1 mux per port followed by a 2:1 bypass mux, with no tristate buses.

Verification
REQ-028 Reset check: assert reset, then read indices 0..31 on both ports -> every read returns 0x00000000.
REQ-029 Basic write: write 0xDEADBEEF to r5 with writeEnable=1, clock once, then read A=5 and B=5 -> both ports return 0xDEADBEEF and r4 and r6 still read 0.
REQ-030 Register zero: write 0x12345678 to r0 and clock -> A=0 returns 0x00000000 and no other register changes.
REQ-031 Bypass: r7=0x11111111, then drive writeReg=7, data=0x22222222, writeEnable=1 and A=7 -> A returns 0x22222222 before the edge; with writeEnable=0 the same inputs return 0x11111111.
REQ-032 Async reset mid-operation: r3=0xFFFFFFFF, assert reset between edges -> r3 reads 0 immediately; a write to r3 while reset=1 has no effect after release.
REQ-033 Full sweep: write index*0x01010101 to r1..r31 and read back all pairs (A=i, B=31-i) -> all values match, with r0 returning 0.
